// File: rtl/mvm_stream_param_if.sv
// mvm_stream_param_if: stream/bus bundle for the matrix-vector multiply engine.
//   Matrix write beat : i_matrix, i_matrix_wren, i_matrix_wrpause
//   Vector beat       : i_v, i_first, i_last, i_pause
//   Result stream     : o_sum, o_first, o_last, o_pause
//   Status            : o_busy, o_overrun
// The master modport is the side that feeds the engine, the slave modport is the engine.
interface mvm_stream_param_if #(
  parameter int B = 16,
  parameter int N = 8,
  parameter int S = 48
);
  logic [B*N-1:0] i_matrix;
  logic           i_matrix_wren;
  logic           i_matrix_wrpause;
  logic [B*N-1:0] i_v;
  logic           i_first;
  logic           i_last;
  logic           i_pause;
  logic [S-1:0]   o_sum;
  logic           o_first;
  logic           o_last;
  logic           o_pause;
  logic           o_busy;
  logic           o_overrun;

  modport master (
    output i_matrix, i_matrix_wren, i_matrix_wrpause,
    output i_v, i_first, i_last, i_pause,
    input  o_sum, o_first, o_last, o_pause, o_busy, o_overrun
  );

  modport slave (
    input  i_matrix, i_matrix_wren, i_matrix_wrpause,
    input  i_v, i_first, i_last, i_pause,
    output o_sum, o_first, o_last, o_pause, o_busy, o_overrun
  );
endinterface

// File: rtl/mvm_stream_param.sv
// mvm_stream_param: streaming matrix-vector multiply engine.
// Holds a VxV matrix of N-bit elements in a block RAM (row-major, B elements per
// word), captures a V-element vector as B-element beats, then streams out the V
// row dot products as S-bit sums, one row every V/B cycles.
// Ports:
//   i_clk   - clock
//   i_reset - asynchronous active-high reset
//   bus     - slave side of mvm_stream_param_if (matrix writes, vector beats,
//             result stream, busy/overrun status)
// Pipeline: RAM read -> multiply -> reduce+accumulate -> output register.
module mvm_stream_param #(
  parameter int V      = 256,
  parameter int B      = 16,
  parameter int N      = 8,
  parameter int S      = 48,
  parameter bit SIGNED = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mvm_stream_param_if.slave bus
);

  localparam int W     = V / B;                          // words per matrix row
  localparam int DEPTH = V * W;                          // matrix RAM words
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (W > 1) ? $clog2(W) : 1;
  localparam int VCW   = $clog2(W + 1);                  // counter can reach W
  localparam int RW    = (V > 1) ? $clog2(V) : 1;

  if (S < 2 * N + $clog2(V)) begin : g_bad_width
    $error("mvm_stream_param: S too small for 2N + clog2(V)");
  end
  if ((V % B) != 0) begin : g_bad_beat
    $error("mvm_stream_param: V must be a multiple of B");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  // Operand extension to 2N bits; the low 2N bits of the product of the
  // extended operands are the exact product in either mode.
  function automatic logic [2*N-1:0] ext_op(input logic [N-1:0] a);
    if (SIGNED && a[N-1]) begin
      return {{N{1'b1}}, a};
    end else begin
      return {{N{1'b0}}, a};
    end
  endfunction

  // Widen a 2N-bit product to the accumulator width.
  function automatic logic [S-1:0] ext_prod(input logic [2*N-1:0] p);
    if (SIGNED && p[2*N-1]) begin
      return {{(S-2*N){1'b1}}, p};
    end else begin
      return {{(S-2*N){1'b0}}, p};
    end
  endfunction

  // Storage
  logic [B*N-1:0] mem_r  [DEPTH];
  logic [B*N-1:0] vbuf_r [W];
  logic [AW-1:0]  wr_addr_r;
  logic           wr_fire_s;

  // Vector capture
  logic           vec_valid_s;
  logic           vec_accept_s;
  logic           vec_store_s;
  logic [CW-1:0]  vec_slot_s;
  logic [VCW-1:0] vcnt_r;
  logic [VCW-1:0] vcnt_nxt_s;

  // Control
  state_t         state_r;
  state_t         state_nxt_s;
  logic           busy_s;
  logic           rd_en_s;
  logic [AW-1:0]  rd_addr_r;
  logic [CW-1:0]  col_r;
  logic [RW-1:0]  row_r;

  // Pipeline
  logic [B*N-1:0] m1_r;
  logic [B*N-1:0] x1_r;
  logic           v1_r, first1_r, end1_r, row0_1_r, lastrow1_r;
  logic [2*N-1:0] prod_s  [B];
  logic [2*N-1:0] prod2_r [B];
  logic           v2_r, first2_r, end2_r, row0_2_r, lastrow2_r;
  logic [S-1:0]   tree_s;
  logic [S-1:0]   acc3_r;
  logic           done3_r, row0_3_r, lastrow3_r;

  // Registered outputs
  logic [S-1:0]   sum_r;
  logic           first_r, last_r, pause_r, busy_r, overrun_r;

  assign wr_fire_s    = bus.i_matrix_wren & ~bus.i_matrix_wrpause;
  assign vec_valid_s  = ~bus.i_pause;
  assign vec_accept_s = vec_valid_s & (state_r == ST_IDLE);

  // Matrix RAM write port plus the registered read stage (no reset: block RAM).
  always_ff @(posedge i_clk) begin
    if (wr_fire_s) begin
      mem_r[wr_addr_r] <= bus.i_matrix;
    end
    m1_r <= mem_r[rd_addr_r];
    x1_r <= vbuf_r[col_r];
  end

  // Vector buffer write port.
  always_ff @(posedge i_clk) begin
    if (vec_store_s) begin
      vbuf_r[vec_slot_s] <= bus.i_v;
    end
  end

  // Vector beat placement: i_first restarts at slot 0, overflow beats are dropped.
  always_comb begin
    vec_store_s = 1'b0;
    vec_slot_s  = '0;
    vcnt_nxt_s  = vcnt_r;
    if (vec_accept_s) begin
      if (bus.i_first) begin
        vec_store_s = 1'b1;
        vec_slot_s  = '0;
        vcnt_nxt_s  = VCW'(1);
      end else if (vcnt_r < VCW'(W)) begin
        vec_store_s = 1'b1;
        vec_slot_s  = vcnt_r[CW-1:0];
        vcnt_nxt_s  = vcnt_r + VCW'(1);
      end else begin
        vec_store_s = 1'b0;
      end
    end else begin
      vec_store_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (vec_accept_s && bus.i_last) state_nxt_s = ST_COMPUTE;
        else                            state_nxt_s = ST_IDLE;
      end
      ST_COMPUTE: begin
        if (rd_addr_r == AW'(DEPTH - 1)) state_nxt_s = ST_DRAIN;
        else                             state_nxt_s = ST_COMPUTE;
      end
      ST_DRAIN: begin
        // Leave on the edge that registers the row V-1 result.
        if (done3_r && lastrow3_r) state_nxt_s = ST_IDLE;
        else                       state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_s  = 1'b0;
    rd_en_s = 1'b0;
    case (state_r)
      ST_IDLE:    begin busy_s = 1'b0; rd_en_s = 1'b0; end
      ST_COMPUTE: begin busy_s = 1'b1; rd_en_s = 1'b1; end
      ST_DRAIN:   begin busy_s = 1'b1; rd_en_s = 1'b0; end
      default:    begin busy_s = 1'b0; rd_en_s = 1'b0; end
    endcase
  end

  // Write address, vector counter and read sequencing counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_addr_r <= '0;
      vcnt_r    <= '0;
      rd_addr_r <= '0;
      col_r     <= '0;
      row_r     <= '0;
    end else begin
      if (wr_fire_s) begin
        wr_addr_r <= (wr_addr_r == AW'(DEPTH - 1)) ? '0 : wr_addr_r + AW'(1);
      end
      vcnt_r <= vcnt_nxt_s;
      if (rd_en_s) begin
        rd_addr_r <= (rd_addr_r == AW'(DEPTH - 1)) ? '0 : rd_addr_r + AW'(1);
        if (col_r == CW'(W - 1)) begin
          col_r <= '0;
          row_r <= (row_r == RW'(V - 1)) ? '0 : row_r + RW'(1);
        end else begin
          col_r <= col_r + CW'(1);
        end
      end else begin
        rd_addr_r <= '0;
        col_r     <= '0;
        row_r     <= '0;
      end
    end
  end

  // Lane multipliers on the RAM/vector words.
  always_comb begin
    for (int k = 0; k < B; k++) begin
      prod_s[k] = ext_op(m1_r[k*N +: N]) * ext_op(x1_r[k*N +: N]);
    end
  end

  // Reduction of the B lane products.
  always_comb begin
    tree_s = '0;
    for (int k = 0; k < B; k++) begin
      tree_s = tree_s + ext_prod(prod2_r[k]);
    end
  end

  // Pipeline control flags, products, accumulator and output register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      v1_r       <= 1'b0;
      first1_r   <= 1'b0;
      end1_r     <= 1'b0;
      row0_1_r   <= 1'b0;
      lastrow1_r <= 1'b0;
      for (int k = 0; k < B; k++) prod2_r[k] <= '0;
      v2_r       <= 1'b0;
      first2_r   <= 1'b0;
      end2_r     <= 1'b0;
      row0_2_r   <= 1'b0;
      lastrow2_r <= 1'b0;
      acc3_r     <= '0;
      done3_r    <= 1'b0;
      row0_3_r   <= 1'b0;
      lastrow3_r <= 1'b0;
      sum_r      <= '0;
      first_r    <= 1'b0;
      last_r     <= 1'b0;
      pause_r    <= 1'b1;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      v1_r       <= rd_en_s;
      first1_r   <= (col_r == '0);
      end1_r     <= (col_r == CW'(W - 1));
      row0_1_r   <= (row_r == '0);
      lastrow1_r <= (row_r == RW'(V - 1));
      prod2_r    <= prod_s;
      v2_r       <= v1_r;
      first2_r   <= first1_r;
      end2_r     <= end1_r;
      row0_2_r   <= row0_1_r;
      lastrow2_r <= lastrow1_r;
      // First word of a row loads, so consecutive rows need no bubble.
      if (v2_r) begin
        acc3_r <= first2_r ? tree_s : acc3_r + tree_s;
      end
      done3_r    <= v2_r & end2_r;
      row0_3_r   <= row0_2_r;
      lastrow3_r <= lastrow2_r;
      if (done3_r) begin
        sum_r   <= acc3_r;
        first_r <= row0_3_r;
        last_r  <= lastrow3_r;
        pause_r <= 1'b0;
      end else begin
        first_r <= 1'b0;
        last_r  <= 1'b0;
        pause_r <= 1'b1;
      end
      busy_r    <= busy_s;
      overrun_r <= vec_valid_s & busy_s;
    end
  end

  assign bus.o_sum     = sum_r;
  assign bus.o_first   = first_r;
  assign bus.o_last    = last_r;
  assign bus.o_pause   = pause_r;
  assign bus.o_busy    = busy_r;
  assign bus.o_overrun = overrun_r;

endmodule

// File: tb/tb_mvm_stream_param.sv
// Testbench for mvm_stream_param: a signed and an unsigned instance (V=8, B=4,
// N=8, S=24) share one stimulus stream; expected sums come from a plain
// integer dot-product model of the matrix and vector held in the bench.
module tb_mvm_stream_param;
  localparam int V     = 8;
  localparam int B     = 4;
  localparam int N     = 8;
  localparam int S     = 24;
  localparam int W     = V / B;
  localparam int DEPTH = V * W;
  localparam int LAT   = V * W + 3;   // cycles from accepting i_last to o_last

  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  mvm_stream_param_if #(.B(B), .N(N), .S(S)) bs ();
  mvm_stream_param_if #(.B(B), .N(N), .S(S)) bu ();

  assign bu.i_matrix         = bs.i_matrix;
  assign bu.i_matrix_wren    = bs.i_matrix_wren;
  assign bu.i_matrix_wrpause = bs.i_matrix_wrpause;
  assign bu.i_v              = bs.i_v;
  assign bu.i_first          = bs.i_first;
  assign bu.i_last           = bs.i_last;
  assign bu.i_pause          = bs.i_pause;

  mvm_stream_param #(.V(V), .B(B), .N(N), .S(S), .SIGNED(1'b1)) u_dut_s (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bs)
  );
  mvm_stream_param #(.V(V), .B(B), .N(N), .S(S), .SIGNED(1'b0)) u_dut_u (
    .i_clk(i_clk), .i_reset(i_reset), .bus(bu)
  );

  logic [N-1:0] mat [V][V];
  logic [N-1:0] vec [V];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [S-1:0] ref_row(input int r, input bit sgn);
    longint acc, a, b;
    acc = 0;
    for (int c = 0; c < V; c++) begin
      a = sgn ? longint'($signed(mat[r][c])) : longint'(mat[r][c]);
      b = sgn ? longint'($signed(vec[c]))    : longint'(vec[c]);
      acc += a * b;
    end
    return acc[S-1:0];
  endfunction

  function automatic logic [B*N-1:0] mat_beat(input int a);
    logic [B*N-1:0] w;
    for (int k = 0; k < B; k++) w[k*N +: N] = mat[a / W][(a % W) * B + k];
    return w;
  endfunction

  function automatic logic [B*N-1:0] vec_beat(input int c);
    logic [B*N-1:0] w;
    for (int k = 0; k < B; k++) w[k*N +: N] = vec[c * B + k];
    return w;
  endfunction

  task automatic load_matrix(input bit gaps);
    for (int a = 0; a < DEPTH; a++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        bs.i_matrix_wren    = 1'b1;
        bs.i_matrix_wrpause = 1'b1;
        bs.i_matrix         = B*N'($urandom);
        tick();
        bs.i_matrix_wren    = 1'b0;
        bs.i_matrix_wrpause = 1'b0;
        bs.i_matrix         = B*N'($urandom);
        tick();
      end
      bs.i_matrix_wren    = 1'b1;
      bs.i_matrix_wrpause = 1'b0;
      bs.i_matrix         = mat_beat(a);
      tick();
    end
    bs.i_matrix_wren    = 1'b0;
    bs.i_matrix_wrpause = 1'b0;
  endtask

  // Ends one edge after the i_last beat is accepted (cycle 0 of the run).
  task automatic send_vector(input bit gaps);
    if (gaps) begin
      // Stray partial beat, later overridden by i_first.
      bs.i_pause = 1'b0; bs.i_first = 1'b0; bs.i_last = 1'b0;
      bs.i_v     = B*N'($urandom);
      tick();
    end
    for (int c = 0; c < W; c++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(1, 2)); g++) begin
          bs.i_pause = 1'b1;
          bs.i_first = 1'($urandom);
          bs.i_last  = 1'($urandom);
          bs.i_v     = B*N'($urandom);
          tick();
        end
      end
      bs.i_pause = 1'b0;
      bs.i_first = (c == 0);
      bs.i_last  = (c == W - 1);
      bs.i_v     = vec_beat(c);
      tick();
    end
    bs.i_pause = 1'b1;
    bs.i_first = 1'b0;
    bs.i_last  = 1'b0;
  endtask

  task automatic check_dut(input string nm, input int k, input int inj_k,
                           input logic [S-1:0] exp_sum, input logic [S-1:0] sum,
                           input logic f, input logic l, input logic p,
                           input logic b, input logic o);
    bit vld;
    int row;
    vld = (k >= W + 3) && (((k - 3) % W) == 0) && (k <= LAT);
    row = (k - 3) / W - 1;
    chk({nm, "_pause"}, 64'(p), 64'(!vld));
    chk({nm, "_busy"}, 64'(b), 64'(k <= LAT));
    chk({nm, "_overrun"}, 64'(o), 64'(inj_k > 0 && k == inj_k + 1));
    if (vld) begin
      chk({nm, "_sum"}, 64'(sum), 64'(exp_sum));
      chk({nm, "_first"}, 64'(f), 64'(row == 0));
      chk({nm, "_last"}, 64'(l), 64'(row == V - 1));
    end
  endtask

  // Runs from cycle 0 to one cycle past o_last; inj_k injects a stray valid
  // beat at that cycle, rst_k asserts reset right after that cycle's checks.
  task automatic check_run(input int inj_k, input int rst_k);
    logic [S-1:0] es [V];
    logic [S-1:0] eu [V];
    int ri;
    for (int r = 0; r < V; r++) begin
      es[r] = ref_row(r, 1'b1);
      eu[r] = ref_row(r, 1'b0);
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      ri = (k - 3) / W - 1;
      if (ri < 0) ri = 0;
      if (ri > V - 1) ri = V - 1;
      check_dut("s", k, inj_k, es[ri], bs.o_sum, bs.o_first, bs.o_last,
                bs.o_pause, bs.o_busy, bs.o_overrun);
      check_dut("u", k, inj_k, eu[ri], bu.o_sum, bu.o_first, bu.o_last,
                bu.o_pause, bu.o_busy, bu.o_overrun);
      if (k == rst_k) begin
        i_reset = 1'b1;
        #1;
        chk("rst_s_pause", 64'(bs.o_pause), 64'(1));
        chk("rst_s_busy",  64'(bs.o_busy),  64'(0));
        chk("rst_u_pause", 64'(bu.o_pause), 64'(1));
        chk("rst_u_busy",  64'(bu.o_busy),  64'(0));
        return;
      end
      if (k == inj_k) begin
        bs.i_pause = 1'b0;
        bs.i_first = 1'b1;
        bs.i_last  = 1'b1;
        bs.i_v     = B*N'($urandom);
      end else begin
        bs.i_pause = 1'b1;
        bs.i_first = 1'b0;
        bs.i_last  = 1'b0;
      end
    end
  endtask

  task automatic rand_data();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < V; c++) mat[r][c] = N'($urandom);
    for (int c = 0; c < V; c++) vec[c] = N'($urandom);
  endtask

  initial begin
    i_reset             = 1'b1;
    bs.i_matrix         = '0;
    bs.i_matrix_wren    = 1'b0;
    bs.i_matrix_wrpause = 1'b0;
    bs.i_v              = '0;
    bs.i_first          = 1'b0;
    bs.i_last           = 1'b0;
    bs.i_pause          = 1'b1;
    tick();
    tick();
    chk("reset_s_sum",     64'(bs.o_sum),     64'(0));
    chk("reset_s_first",   64'(bs.o_first),   64'(0));
    chk("reset_s_last",    64'(bs.o_last),    64'(0));
    chk("reset_s_pause",   64'(bs.o_pause),   64'(1));
    chk("reset_s_busy",    64'(bs.o_busy),    64'(0));
    chk("reset_s_overrun", 64'(bs.o_overrun), 64'(0));
    chk("reset_u_pause",   64'(bu.o_pause),   64'(1));
    chk("reset_u_busy",    64'(bu.o_busy),    64'(0));
    i_reset = 1'b0;
    tick();

    // Identity matrix, vector 1..8: each row returns its own index + 1.
    for (int r = 0; r < V; r++)
      for (int c = 0; c < V; c++) mat[r][c] = (r == c) ? N'(1) : N'(0);
    for (int c = 0; c < V; c++) vec[c] = N'(c + 1);
    load_matrix(1'b0);
    send_vector(1'b0);
    check_run(0, 0);

    // All -128 (signed extreme), with paused load and vector beats.
    for (int r = 0; r < V; r++)
      for (int c = 0; c < V; c++) mat[r][c] = N'(8'h80);
    for (int c = 0; c < V; c++) vec[c] = N'(8'h80);
    load_matrix(1'b1);
    send_vector(1'b1);
    check_run(0, 0);

    // All 0xFF: 255 in unsigned mode, -1 in signed mode.
    for (int r = 0; r < V; r++)
      for (int c = 0; c < V; c++) mat[r][c] = N'(8'hFF);
    for (int c = 0; c < V; c++) vec[c] = N'(8'hFF);
    load_matrix(1'b0);
    send_vector(1'b0);
    check_run(0, 0);

    // Random matrices and vectors with random stalls.
    for (int it = 0; it < 3; it++) begin
      rand_data();
      load_matrix(1'b1);
      send_vector(1'b1);
      check_run(0, 0);
    end

    // Stray vector beat during COMPUTE: dropped, one overrun pulse.
    for (int c = 0; c < V; c++) vec[c] = N'($urandom);
    send_vector(1'b0);
    check_run(4, 0);

    // Reset while row 3 is presented, then a fresh vector.
    for (int c = 0; c < V; c++) vec[c] = N'($urandom);
    send_vector(1'b0);
    check_run(0, 4 * W + 3);
    bs.i_pause = 1'b1;
    tick();
    tick();
    chk("inrst_s_sum",  64'(bs.o_sum),  64'(0));
    chk("inrst_s_busy", 64'(bs.o_busy), 64'(0));
    chk("inrst_u_sum",  64'(bu.o_sum),  64'(0));
    i_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("postrst_s_pause", 64'(bs.o_pause), 64'(1));
      chk("postrst_u_pause", 64'(bu.o_pause), 64'(1));
    end
    for (int c = 0; c < V; c++) vec[c] = N'($urandom);
    send_vector(1'b1);
    check_run(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
